// File: rtl/riscv_defs.sv
// Shared fetch-stage definitions: instruction constants and fetch FSM encoding.
package riscv_defs;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order instruction buffer with push/pop and a single-cycle flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + ($clog2(DEPTH)+1)'(push) - ($clog2(DEPTH)+1)'(pop);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues imem word requests under a credit limit, buffers
// in-order returns, delivers {instr, pc} to decode, and handles redirects.
module instr_fetch
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        fetch_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state;
    logic [31:0]     fetch_pc;
    logic [31:0]     deliver_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [XLEN-1:0] fifo_head;
    logic            issue;
    logic            push;
    logic            pop;
    logic            misaligned;
    logic [CW:0]     credit_used;
    logic [CW:0]     drop_next;

    // Every issued-but-unreturned word plus every buffered word holds a slot,
    // which is what makes FIFO overflow impossible.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req    = ((state == S_FETCH) || (state == S_FLUSH)) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc;
    assign issue       = imem_req && imem_gnt;

    // A same-cycle redirect kills both the arriving word and the pop.
    assign push        = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    assign pop         = if_valid && if_ready && !redirect_valid;
    assign misaligned  = |redirect_pc[1:0];
    assign drop_next   = {1'b0, outstanding} + (CW+1)'(issue) - (CW+1)'(imem_rvalid);

    assign if_valid    = !fifo_empty && (state != S_ERR);
    assign if_instr    = if_valid ? fifo_head : NOP_INSTR;
    assign if_pc       = deliver_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (imem_rdata),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Fetch FSM with PC, in-flight and drop bookkeeping; redirect has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            deliver_pc  <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc;
                deliver_pc <= redirect_pc;
                drop_cnt   <= drop_next[CW-1:0];
                fetch_err  <= misaligned;
                if (misaligned)              state <= S_ERR;
                else if (drop_next != '0)    state <= S_FLUSH;
                else                         state <= S_FETCH;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (pop)   deliver_pc <= deliver_pc + 32'd4;
                if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
                case (state)
                    S_IDLE:  state <= S_FETCH;
                    S_FLUSH: if (drop_cnt == CW'(imem_rvalid)) state <= S_FETCH;
                    default: state <= state;
                endcase
            end
        end
    end

    // A response with nothing in flight means the memory broke the protocol.
    assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queue-based memory plus an in-order
// program-counter model of what decode should see.
module tb_instr_fetch;
    import riscv_defs::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        fetch_err;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mq[$];        // addresses granted, awaiting response
    logic [31:0] exp_pc;       // next pc decode should receive
    logic [31:0] exp_fetch;    // next address memory should be asked for
    logic        exp_err;
    logic        hold_chk;
    logic [31:0] hold_addr;
    int          delivered;
    int          grants;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus and model update; entered and left at posedge+1.
    task automatic step(input int pg, input int prv, input int prdy,
                        input logic rd, input logic [31:0] rpc);
        logic        g, rv, rq;
        logic [31:0] ad;
        rq = imem_req;
        ad = imem_addr;
        if (hold_chk) begin
            chk("req_hold", 32'(rq), 32'd1);
            chk("addr_hold", ad, hold_addr);
        end
        g  = rq && ($urandom_range(99) < pg);
        rv = (mq.size() != 0) && ($urandom_range(99) < prv);
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(mq[0]) : $urandom;
        if_ready       = ($urandom_range(99) < prdy);
        redirect_valid = rd;
        redirect_pc    = rpc;
        chk("fetch_err", 32'(fetch_err), 32'(exp_err));
        if (exp_err) begin
            chk("err_req", 32'(rq), 32'd0);
            chk("err_valid", 32'(if_valid), 32'd0);
        end
        if (!if_valid) chk("nop", if_instr, NOP_INSTR);
        if (rv) void'(mq.pop_front());
        if (g) begin
            chk("fetch_addr", ad, exp_fetch);
            mq.push_back(ad);
            exp_fetch = exp_fetch + 32'd4;
            grants++;
        end
        if (mq.size() > FIFO_DEPTH) chk("credit", 32'(mq.size()), 32'(FIFO_DEPTH));
        if (rd) begin
            exp_pc    = rpc;
            exp_fetch = rpc;
            exp_err   = |rpc[1:0];
        end else if (if_valid && if_ready) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        hold_chk  = rq && !g && !rd;
        hold_addr = ad;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset entry with immediate output check, then release.
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        mq.delete();
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        exp_err   = 1'b0;
        hold_chk  = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, NOP_INSTR);
        chk("rst_pc", if_pc, RESET_PC);
        chk("rst_err", 32'(fetch_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        logic found;
        delivered = 0;
        grants    = 0;

        // Zero-wait memory: first word two cycles after leaving IDLE, then streaming.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk("first_valid", 32'(if_valid), 32'(k == 2));
            step(100, 100, 100, 1'b0, '0);
        end
        d0 = delivered;
        repeat (10) step(100, 100, 100, 1'b0, '0);
        chk("zw_progress", 32'(delivered - d0 >= 4), 32'd1);

        // Backpressure: only two fetches fit, then request must drop.
        do_reset();
        grants = 0;
        repeat (6) step(100, 100, 0, 1'b0, '0);
        chk("bp_grants", 32'(grants), 32'd2);
        chk("bp_req", 32'(imem_req), 32'd0);
        repeat (10) step(100, 100, 100, 1'b0, '0);
        chk("bp_resume", 32'(exp_pc >= 32'd12), 32'd1);

        // Redirect while two responses are held back by the memory.
        do_reset();
        repeat (3) step(100, 0, 100, 1'b0, '0);
        step(100, 0, 100, 1'b1, 32'h100);
        repeat (12) step(100, 100, 100, 1'b0, '0);
        chk("redir100_resume", 32'(exp_pc >= 32'h104), 32'd1);

        // Redirect coinciding with a grant and a response.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found && imem_req && mq.size() != 0) begin
                found = 1'b1;
                step(100, 100, 100, 1'b1, 32'h40);
            end else begin
                step(100, 100, 100, 1'b0, '0);
            end
        end
        chk("redir40_found", 32'(found), 32'd1);
        chk("redir40_resume", 32'(exp_pc >= 32'h44), 32'd1);

        // Misaligned redirect parks fetch until an aligned one arrives.
        step(100, 100, 100, 1'b1, 32'h102);
        repeat (5) step(100, 100, 100, 1'b0, '0);
        chk("err_flag", 32'(fetch_err), 32'd1);
        step(100, 100, 100, 1'b1, 32'h200);
        repeat (12) step(100, 100, 100, 1'b0, '0);
        chk("err_clear", 32'(fetch_err), 32'd0);
        chk("redir200_resume", 32'(exp_pc >= 32'h204), 32'd1);

        // Wrap of the fetch address at the top of the address space.
        step(100, 100, 100, 1'b1, 32'hFFFF_FFF8);
        repeat (12) step(100, 100, 100, 1'b0, '0);
        chk("wrap_resume", 32'(exp_pc >= 32'h4 && exp_pc < 32'h100), 32'd1);

        // Random traffic with random redirects, some misaligned.
        for (int i = 0; i < 1500; i++) begin
            logic        rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(99) < 3);
            rpc = {20'h0, 10'($urandom), ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'b00};
            step(60, 60, 70, rd, rpc);
        end
        step(100, 100, 100, 1'b1, 32'h300);
        d0 = delivered;
        repeat (20) step(100, 100, 100, 1'b0, '0);
        chk("rand_progress", 32'(delivered - d0 >= 4), 32'd1);

        // Asynchronous reset asserted between clock edges mid-stream.
        #2;
        do_reset();
        repeat (12) step(100, 100, 100, 1'b0, '0);
        chk("post_reset_resume", 32'(exp_pc >= RESET_PC + 32'd8), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
